// File: rtl/arb_input_queue.sv
// -----------------------------------------------------------------------------
// arb_input_queue
//   Five-channel input buffer placed in front of a 5-way round-robin arbiter.
//   Each channel has its own small circular FIFO. A producer writes into it
//   with valid/ready. The arbiter sees the non-empty flags as request[4:0] and
//   the head-of-queue words as data_0..data_4. The arbiter's grant[4:0] is
//   used as a pop strobe, so one word leaves each granted channel per cycle.
//
// Ports
//   clk                  rising-edge clock
//   reset                synchronous, active-high reset
//   in_valid[4:0]        producer c offers in_data_c this cycle
//   in_ready[4:0]        channel c is not full
//   in_data_0..in_data_4 producer words, one per channel
//   grant[4:0]           arbiter grant, expected one-hot or zero
//   request[4:0]         channel c FIFO is non-empty
//   data_0..data_4       head word of each channel (don't-care while empty)
//   err_grant            sticky; set when a grant targets an empty channel or
//                        when grant is not one-hot. Cleared only by reset.
// -----------------------------------------------------------------------------
module arb_input_queue #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        in_valid,
  output logic [4:0]        in_ready,
  input  logic [DATA_W-1:0] in_data_0,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic [DATA_W-1:0] in_data_3,
  input  logic [DATA_W-1:0] in_data_4,
  input  logic [4:0]        grant,
  output logic [4:0]        request,
  output logic [DATA_W-1:0] data_0,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2,
  output logic [DATA_W-1:0] data_3,
  output logic [DATA_W-1:0] data_4,
  output logic              err_grant
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  // Collect the per-channel ports into arrays so that the generate loop can
  // index them.
  logic [DATA_W-1:0] in_data_arr [5];
  logic [DATA_W-1:0] head_arr    [5];

  assign in_data_arr[0] = in_data_0;
  assign in_data_arr[1] = in_data_1;
  assign in_data_arr[2] = in_data_2;
  assign in_data_arr[3] = in_data_3;
  assign in_data_arr[4] = in_data_4;

  assign data_0 = head_arr[0];
  assign data_1 = head_arr[1];
  assign data_2 = head_arr[2];
  assign data_3 = head_arr[3];
  assign data_4 = head_arr[4];

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_chan
      logic [DATA_W-1:0] mem_q [DEPTH];
      logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
      logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
      logic [AW:0]       count_q, count_d;
      logic              push, pop;

      assign in_ready[gi] = (count_q != FULL_COUNT);
      assign request[gi]  = (count_q != '0);
      assign head_arr[gi] = mem_q[rd_ptr_q];

      // Push is gated by this cycle's in_ready. A pop does not free a slot
      // early, so a full channel refuses a push even while it is being popped.
      always_comb begin
        push     = in_valid[gi] & in_ready[gi];
        pop      = grant[gi] & request[gi];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      // Storage is left uncleared on reset. A write that happens during reset
      // is harmless because the pointers return to zero anyway.
      always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data_arr[gi];
      end
    end
  endgenerate

  // Sticky grant-protocol error.
  logic err_q, err_d;
  logic bad_target, multi_grant;

  always_comb begin
    bad_target  = |(grant & ~request);
    multi_grant = (grant & (grant - 5'd1)) != 5'd0;
    err_d       = err_q | bad_target | multi_grant;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_grant = err_q;

endmodule

// File: tb/tb_arb_input_queue.sv
module tb_arb_input_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  in_valid;
  logic [4:0]  in_ready;
  logic [15:0] wdata;
  logic [4:0]  grant;
  logic [4:0]  request;
  logic [15:0] data_0, data_1, data_2, data_3, data_4;
  logic        err_grant;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  arb_input_queue #(.DATA_W(16), .DEPTH(4), .AW(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data_0(wdata),
    .in_data_1(wdata),
    .in_data_2(wdata),
    .in_data_3(wdata),
    .in_data_4(wdata),
    .grant    (grant),
    .request  (request),
    .data_0   (data_0),
    .data_1   (data_1),
    .data_2   (data_2),
    .data_3   (data_3),
    .data_4   (data_4),
    .err_grant(err_grant)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  valid;
    logic [4:0]  gnt;
    logic [15:0] wd;
    logic [4:0]  exp_req;
    logic [4:0]  exp_rdy;
    logic        exp_err;
    logic        chk;
    int          ch;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [15:0] head(input int ch);
    case (ch)
      0: return data_0;
      1: return data_1;
      2: return data_2;
      3: return data_3;
      default: return data_4;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // Drive inputs, wait for the edge, then settle 1 time unit after it.
  task automatic cycle(input logic r, input logic [4:0] v, input logic [4:0] g, input logic [15:0] d);
    reset = r; in_valid = v; grant = g; wdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Expected outputs are the state seen just after the edge that applied the row.
    vecs[0]  = '{1'b1, 5'h00, 5'h00, 16'h0000, 5'h00, 5'h1F, 1'b0, 1'b0, 0, 16'h0000}; // reset
    vecs[1]  = '{1'b0, 5'h00, 5'h00, 16'h0000, 5'h00, 5'h1F, 1'b0, 1'b0, 0, 16'h0000}; // idle
    vecs[2]  = '{1'b0, 5'h04, 5'h00, 16'hA001, 5'h04, 5'h1F, 1'b0, 1'b1, 2, 16'hA001}; // push ch2
    vecs[3]  = '{1'b0, 5'h00, 5'h00, 16'h0000, 5'h04, 5'h1F, 1'b0, 1'b1, 2, 16'hA001};
    vecs[4]  = '{1'b0, 5'h00, 5'h04, 16'h0000, 5'h00, 5'h1F, 1'b0, 1'b0, 0, 16'h0000}; // pop ch2
    vecs[5]  = '{1'b0, 5'h01, 5'h00, 16'h0001, 5'h01, 5'h1F, 1'b0, 1'b1, 0, 16'h0001};
    vecs[6]  = '{1'b0, 5'h01, 5'h00, 16'h0002, 5'h01, 5'h1F, 1'b0, 1'b1, 0, 16'h0001};
    vecs[7]  = '{1'b0, 5'h01, 5'h00, 16'h0003, 5'h01, 5'h1F, 1'b0, 1'b1, 0, 16'h0001};
    vecs[8]  = '{1'b0, 5'h01, 5'h00, 16'h0004, 5'h01, 5'h1E, 1'b0, 1'b1, 0, 16'h0001}; // full
    vecs[9]  = '{1'b0, 5'h01, 5'h00, 16'h0005, 5'h01, 5'h1E, 1'b0, 1'b1, 0, 16'h0001}; // 5th held
    vecs[10] = '{1'b0, 5'h01, 5'h01, 16'h0005, 5'h01, 5'h1F, 1'b0, 1'b1, 0, 16'h0002}; // pop only
    vecs[11] = '{1'b0, 5'h01, 5'h00, 16'h0005, 5'h01, 5'h1E, 1'b0, 1'b1, 0, 16'h0002}; // 5th in
    vecs[12] = '{1'b0, 5'h00, 5'h01, 16'h0000, 5'h01, 5'h1F, 1'b0, 1'b1, 0, 16'h0003};
    vecs[13] = '{1'b0, 5'h00, 5'h01, 16'h0000, 5'h01, 5'h1F, 1'b0, 1'b1, 0, 16'h0004};
    vecs[14] = '{1'b0, 5'h00, 5'h01, 16'h0000, 5'h01, 5'h1F, 1'b0, 1'b1, 0, 16'h0005};
    vecs[15] = '{1'b0, 5'h00, 5'h01, 16'h0000, 5'h00, 5'h1F, 1'b0, 1'b0, 0, 16'h0000}; // drained
    vecs[16] = '{1'b0, 5'h00, 5'h02, 16'h0000, 5'h00, 5'h1F, 1'b1, 1'b0, 0, 16'h0000}; // empty grant
    vecs[17] = '{1'b0, 5'h00, 5'h00, 16'h0000, 5'h00, 5'h1F, 1'b1, 1'b0, 0, 16'h0000}; // sticky
    vecs[18] = '{1'b0, 5'h00, 5'h00, 16'h0000, 5'h00, 5'h1F, 1'b1, 1'b0, 0, 16'h0000};
    vecs[19] = '{1'b0, 5'h10, 5'h00, 16'hC000, 5'h10, 5'h1F, 1'b1, 1'b1, 4, 16'hC000}; // ch4 first

    reset = 1'b1; in_valid = '0; grant = '0; wdata = '0;
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].rst, vecs[i].valid, vecs[i].gnt, vecs[i].wd);
      check($sformatf("v%0d_request", i),   32'(request),   32'(vecs[i].exp_req));
      check($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].exp_rdy));
      check($sformatf("v%0d_err_grant", i), 32'(err_grant), 32'(vecs[i].exp_err));
      if (vecs[i].chk)
        check($sformatf("v%0d_data_%0d", i, vecs[i].ch), 32'(head(vecs[i].ch)), 32'(vecs[i].exp_data));
      $display("vec %0d: valid=%h grant=%h request=%h in_ready=%h err=%b",
               i, vecs[i].valid, vecs[i].gnt, request, in_ready, err_grant);
    end

    // Ch4 now holds C000. Add C001, then push and pop together for 10 cycles.
    // The pointers wrap several times during this.
    begin
      logic [15:0] q[$];
      q.push_back(16'hC000);
      cycle(1'b0, 5'h10, 5'h00, 16'hC001);
      q.push_back(16'hC001);
      for (int i = 0; i < 10; i++) begin
        logic [15:0] w;
        w = 16'hC002 + 16'(i);
        cycle(1'b0, 5'h10, 5'h10, w);
        void'(q.pop_front());
        q.push_back(w);
        check($sformatf("pp%0d_data_4", i), 32'(data_4), 32'(q[0]));
        check($sformatf("pp%0d_req_rdy_4", i), {30'd0, request[4], in_ready[4]}, 32'h3);
        $display("push+pop %0d: wrote %h head %h", i, w, data_4);
      end
      cycle(1'b0, 5'h00, 5'h10, 16'h0000);
      check("drain1_data_4", 32'(data_4), 32'(q[1]));
      check("drain1_request", 32'(request), 32'h10);
      cycle(1'b0, 5'h00, 5'h10, 16'h0000);
      check("drain2_request", 32'(request), 32'h00);
      $display("ch4 drained: request=%h", request);
    end

    // Fill every channel with 3 words, then reset while pushing.
    for (int i = 0; i < 3; i++) cycle(1'b0, 5'h1F, 5'h00, 16'hD000 + 16'(i));
    check("fill_request", 32'(request), 32'h1F);
    check("fill_data_3", 32'(data_3), 32'hD000);
    cycle(1'b1, 5'h1F, 5'h00, 16'hEEEE);
    check("rst_request", 32'(request), 32'h00);
    check("rst_in_ready", 32'(in_ready), 32'h1F);
    check("rst_err_grant", 32'(err_grant), 32'h0);
    cycle(1'b0, 5'h00, 5'h00, 16'h0000);
    check("rst_push_lost", 32'(request), 32'h00);
    $display("reset mid-op: request=%h in_ready=%h err=%b", request, in_ready, err_grant);

    // A multi-bit grant on two valid channels pops both and flags an error.
    cycle(1'b0, 5'h09, 5'h00, 16'hB00B);
    check("mg_request", 32'(request), 32'h09);
    check("mg_err_before", 32'(err_grant), 32'h0);
    cycle(1'b0, 5'h00, 5'h09, 16'h0000);
    check("mg_request_after", 32'(request), 32'h00);
    check("mg_err_after", 32'(err_grant), 32'h1);
    $display("multi-grant: request=%h err=%b", request, err_grant);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
